pll_reset_sequencer: RTL

- Consumes the iCE40 PLL `locked` flag and generates a clean system reset for the 48 MHz SUMP2 core.
- Runs on the free-running 12 MHz board clock.
- Holds the core in reset until lock has been stable for a programmable time, and re-enters reset on loss of lock.
- Keeps loss-of-lock statistics for the host.

---
 rtl/pll_reset_sequencer_pkg.sv | 25 ++
 rtl/pll_reset_sequencer_sync_chain.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared state encoding and counter sizing for the PLL reset sequencer.
// Latency: n/a (types and constants only). Backpressure: n/a.
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_PLLRST = 2'd3
  } state_t;

  // One counter width wide enough for the stability, timeout and pulse counts.
  function automatic int cnt_width(input int stable_cycles,
                                   input int timeout_cycles,
                                   input int pll_reset_cycles);
    int w;
    w = $clog2(stable_cycles + 1);
    if ($clog2(timeout_cycles + 1) > w) w = $clog2(timeout_cycles + 1);
    if ($clog2(pll_reset_cycles + 1) > w) w = $clog2(pll_reset_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_CNT_W = cnt_width(1024, 120000, 16);

endpackage

// File: rtl/pll_reset_sequencer_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level, clears to 0 on reset.
// Latency: STAGES clock edges. Backpressure: none, free-running level path.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the PLL lock flag into a clean core reset and tracks lock-loss statistics.
// Latency: release SYNC_STAGES+STABLE_CYCLES edges after lock, loss SYNC_STAGES+1. Backpressure: none.
// Watchdog/PLL re-reset retry is built only with PLL_RESET_SEQUENCER_WATCHDOG_EN defined.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int STABLE_CYCLES    = 1024,
  parameter int CNT_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES   = 120000,
  parameter int PLL_RESET_CYCLES = 16
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 locked,
  input  logic                 clear_stats,
  output logic                 sys_reset_n,
  output logic                 ready,
  output logic                 lock_lost,
  output logic [CNT_WIDTH-1:0] lost_count,
  output logic                 pll_resetb
);

  localparam int            CW          = cnt_width(STABLE_CYCLES, TIMEOUT_CYCLES, PLL_RESET_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  logic          lock_s;
  logic          run_loss;
  state_t        state_q, state_d;
  logic [CW-1:0] stab_q, stab_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clock_in),
    .rst_n(reset_n),
    .d    (locked),
    .q    (lock_s)
  );

`ifdef PLL_RESET_SEQUENCER_WATCHDOG_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] PLS_LAST = CW'(PLL_RESET_CYCLES - 1);

  logic [CW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] pls_q, pls_d;
`endif

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      ST_WAIT: begin
        stab_d = '0;
        if (lock_s) begin
          // The WAIT cycle that first sees lock already counts toward stability.
          if (STABLE_CYCLES == 1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STABLE;
            stab_d  = CW'(1);
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          stab_d  = '0;
        end else if (stab_q == STABLE_LAST) begin
          state_d = ST_RUN;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + CW'(1);
        end
      end
      ST_RUN: begin
        stab_d = '0;
        if (!lock_s) state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
        stab_d  = '0;
      end
    endcase

`ifdef PLL_RESET_SEQUENCER_WATCHDOG_EN
    tmo_d = '0;
    pls_d = '0;
    if (state_q == ST_WAIT || state_q == ST_STABLE) begin
      // Timeout wins over a same-cycle transition into RUN.
      if (tmo_q == TMO_LAST) begin
        state_d = ST_PLLRST;
        stab_d  = '0;
      end else if (state_d != ST_RUN) begin
        tmo_d = tmo_q + CW'(1);
      end
    end else if (state_q == ST_PLLRST) begin
      if (pls_q == PLS_LAST) begin
        state_d = ST_WAIT;
      end else begin
        pls_d = pls_q + CW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_WAIT;
      stab_q      <= '0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stab_q      <= stab_d;
      sys_reset_n <= (state_d == ST_RUN);
      ready       <= (state_d == ST_RUN);
    end
  end

`ifdef PLL_RESET_SEQUENCER_WATCHDOG_EN
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q      <= '0;
      pls_q      <= '0;
      pll_resetb <= 1'b1;
    end else begin
      tmo_q      <= tmo_d;
      pls_q      <= pls_d;
      pll_resetb <= (state_d != ST_PLLRST);
    end
  end
`else
  assign pll_resetb = 1'b1;
`endif

  assign run_loss = (state_q == ST_RUN) && !lock_s;

  // A loss on the same edge as clear_stats is recorded on top of the clear.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost  <= 1'b0;
      lost_count <= '0;
    end else if (run_loss) begin
      lock_lost  <= 1'b1;
      if (clear_stats) begin
        lost_count <= CNT_WIDTH'(1);
      end else if (!(&lost_count)) begin
        lost_count <= lost_count + CNT_WIDTH'(1);
      end
    end else if (clear_stats) begin
      lock_lost  <= 1'b0;
      lost_count <= '0;
    end
  end

endmodule
